seq_pattern_gen_moore: RTL and testbench

Serial bit-pattern transmitter built as a registered Moore FSM. It produces the serial `x` stream that the team's sequence detectors consume. On a start request it captures a PAT_W-bit pattern and drives it MSB-first, one bit per clock, repeated a programmable number of times. Repetitions can be separated by idle gap cycles. It is the stimulus/transmit end of the serial detector interface and is used in both datapath and bench contexts.

---
 rtl/seq_pattern_gen_moore.sv | 205 ++++++++++++++++++++
 tb/tb_seq_pattern_gen_moore.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen_moore.sv
// seq_pattern_gen_moore
// Serial bit-pattern transmitter built as a registered Moore FSM.
// On start it captures a PAT_W-bit pattern and its configuration, then
// drives the pattern MSB-first on x_out, one bit per clock. The pattern
// is repeated repeat_cnt times, and gap_len idle cycles separate the
// repetitions. done pulses for one cycle after normal completion.
// abort cancels an active transmission without pulsing done.
// All outputs are registered.

module seq_pattern_gen_moore #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             idle_lvl,
  input  logic             abort,
  output logic             x_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  // Bit index wide enough to address every pattern bit.
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r;
  logic [PAT_W-1:0]   pat_r;        // captured pattern
  logic [CNT_W-1:0]   rep_r;        // repetitions left, current one included
  logic [GAP_W-1:0]   gap_len_r;    // captured gap length
  logic               idle_r;       // captured idle line level
  logic [IDX_W-1:0]   bit_idx_r;    // index of the bit now on x_out
  logic [GAP_W-1:0]   gap_cnt_r;    // gap cycles left after the current one

  logic [IDX_W-1:0]   next_idx_s;
  logic               last_bit_s;
  logic               last_rep_s;
  logic               has_gap_s;
  logic               gap_last_s;
  logic               start_ok_s;
  logic               cnt_zero_s;

  // Decode the counter conditions that steer the FSM.
  always_comb begin
    next_idx_s = bit_idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
    last_bit_s = (bit_idx_r == {IDX_W{1'b0}});
    // A count of 1 or less means this repetition is the last one, so the
    // counter never wraps below zero.
    last_rep_s = (rep_r <= {{(CNT_W-1){1'b0}}, 1'b1});
    has_gap_s  = (gap_len_r != {GAP_W{1'b0}});
    gap_last_s = (gap_cnt_r == {GAP_W{1'b0}});
    // abort takes priority over start while idle.
    if (start && !abort) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
    cnt_zero_s = (repeat_cnt == {CNT_W{1'b0}});
  end

  // FSM state, captured configuration, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pat_r     <= {PAT_W{1'b0}};
      rep_r     <= {CNT_W{1'b0}};
      gap_len_r <= {GAP_W{1'b0}};
      idle_r    <= 1'b0;
      bit_idx_r <= {IDX_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      x_out     <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start_ok_s) begin
            pat_r     <= pattern;
            rep_r     <= repeat_cnt;
            gap_len_r <= gap_len;
            idle_r    <= idle_lvl;
            bit_idx_r <= MSB_IDX;
            gap_cnt_r <= {GAP_W{1'b0}};
            if (cnt_zero_s) begin
              // Nothing to send: go straight to the completion pulse.
              state_r <= ST_DONE;
              x_out   <= idle_lvl;
              valid   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_SEND;
              x_out   <= pattern[PAT_W-1];
              valid   <= 1'b1;
              busy    <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            x_out   <= idle_r;
            valid   <= 1'b0;
            busy    <= 1'b0;
          end
        end

        ST_SEND: begin
          if (abort) begin
            state_r <= ST_IDLE;
            x_out   <= idle_r;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (!last_bit_s) begin
            // Advance to the next lower bit of the same repetition.
            bit_idx_r <= next_idx_s;
            x_out     <= pat_r[next_idx_s];
            valid     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else if (last_rep_s) begin
            // LSB of the final repetition has been sent.
            rep_r   <= {CNT_W{1'b0}};
            state_r <= ST_DONE;
            x_out   <= idle_r;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (has_gap_s) begin
            rep_r     <= rep_r - {{(CNT_W-1){1'b0}}, 1'b1};
            state_r   <= ST_GAP;
            gap_cnt_r <= gap_len_r - {{(GAP_W-1){1'b0}}, 1'b1};
            x_out     <= idle_r;
            valid     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else begin
            // No gap: the next repetition's MSB follows back-to-back.
            rep_r     <= rep_r - {{(CNT_W-1){1'b0}}, 1'b1};
            state_r   <= ST_SEND;
            bit_idx_r <= MSB_IDX;
            x_out     <= pat_r[PAT_W-1];
            valid     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        ST_GAP: begin
          if (abort) begin
            state_r <= ST_IDLE;
            x_out   <= idle_r;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (gap_last_s) begin
            state_r   <= ST_SEND;
            bit_idx_r <= MSB_IDX;
            x_out     <= pat_r[PAT_W-1];
            valid     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
            x_out     <= idle_r;
            valid     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        ST_DONE: begin
          // Single-cycle completion state; start and abort are ignored.
          state_r <= ST_IDLE;
          x_out   <= idle_r;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          x_out   <= idle_r;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen_moore.sv
// Directed self-checking bench for seq_pattern_gen_moore.
// Cycle n is the period after clock edge n-1; the start request is
// applied before edge 0. Each 16-bit expected vector holds cycle 1 in
// its leftmost bit.

module tb_seq_pattern_gen_moore;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_cnt;
  logic [2:0] gap_len;
  logic       idle_lvl;
  logic       abort;
  logic       x_out;
  logic       valid;
  logic       busy;
  logic       done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] xs, vs, bs, ds;

  seq_pattern_gen_moore #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .idle_lvl   (idle_lvl),
    .abort      (abort),
    .x_out      (x_out),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record 16 cycles of outputs; cycle 1 lands in bit 15.
  task automatic capture(output logic [15:0] cx, output logic [15:0] cv,
                         output logic [15:0] cb, output logic [15:0] cd);
    for (int c = 1; c <= 16; c++) begin
      cx[16-c] = x_out;
      cv[16-c] = valid;
      cb[16-c] = busy;
      cd[16-c] = done;
      step();
    end
  endtask

  task automatic launch(input logic [3:0] p, input logic [3:0] r,
                        input logic [2:0] g, input logic il);
    pattern    = p;
    repeat_cnt = r;
    gap_len    = g;
    idle_lvl   = il;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({x_out, valid, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got x/v/b/d=%b required 0000", {x_out, valid, busy, done});
    end
  endtask

  task automatic test_single();
    launch(4'b0100, 4'd1, 3'd0, 1'b0);
    capture(xs, vs, bs, ds);
    tests_run++;
    if (xs !== 16'b0100_0000_0000_0000) begin tests_failed++; $display("FAIL single_x: got %b required %b", xs, 16'b0100_0000_0000_0000); end
    tests_run++;
    if (vs !== 16'b1111_0000_0000_0000) begin tests_failed++; $display("FAIL single_valid: got %b required %b", vs, 16'b1111_0000_0000_0000); end
    tests_run++;
    if (bs !== 16'b1111_0000_0000_0000) begin tests_failed++; $display("FAIL single_busy: got %b required %b", bs, 16'b1111_0000_0000_0000); end
    tests_run++;
    if (ds !== 16'b0000_1000_0000_0000) begin tests_failed++; $display("FAIL single_done: got %b required %b", ds, 16'b0000_1000_0000_0000); end
  endtask

  task automatic test_gap();
    launch(4'b0100, 4'd2, 3'd2, 1'b1);
    capture(xs, vs, bs, ds);
    tests_run++;
    if (xs !== 16'b0100_1101_0011_1111) begin tests_failed++; $display("FAIL gap_x: got %b required %b", xs, 16'b0100_1101_0011_1111); end
    tests_run++;
    if (vs !== 16'b1111_0011_1100_0000) begin tests_failed++; $display("FAIL gap_valid: got %b required %b", vs, 16'b1111_0011_1100_0000); end
    tests_run++;
    if (bs !== 16'b1111_1111_1100_0000) begin tests_failed++; $display("FAIL gap_busy: got %b required %b", bs, 16'b1111_1111_1100_0000); end
    tests_run++;
    if (ds !== 16'b0000_0000_0010_0000) begin tests_failed++; $display("FAIL gap_done: got %b required %b", ds, 16'b0000_0000_0010_0000); end
  endtask

  task automatic test_back_to_back();
    launch(4'b1011, 4'd3, 3'd0, 1'b0);
    capture(xs, vs, bs, ds);
    tests_run++;
    if (xs !== 16'b1011_1011_1011_0000) begin tests_failed++; $display("FAIL b2b_x: got %b required %b", xs, 16'b1011_1011_1011_0000); end
    tests_run++;
    if (vs !== 16'b1111_1111_1111_0000) begin tests_failed++; $display("FAIL b2b_valid: got %b required %b", vs, 16'b1111_1111_1111_0000); end
    tests_run++;
    if (bs !== 16'b1111_1111_1111_0000) begin tests_failed++; $display("FAIL b2b_busy: got %b required %b", bs, 16'b1111_1111_1111_0000); end
    tests_run++;
    if (ds !== 16'b0000_0000_0000_1000) begin tests_failed++; $display("FAIL b2b_done: got %b required %b", ds, 16'b0000_0000_0000_1000); end
  endtask

  task automatic test_zero_repeat();
    launch(4'b1111, 4'd0, 3'd3, 1'b0);
    capture(xs, vs, bs, ds);
    tests_run++;
    if (vs !== 16'h0000) begin tests_failed++; $display("FAIL zero_valid: got %b required %b", vs, 16'h0000); end
    tests_run++;
    if (bs !== 16'h0000) begin tests_failed++; $display("FAIL zero_busy: got %b required %b", bs, 16'h0000); end
    tests_run++;
    if (ds !== 16'b1000_0000_0000_0000) begin tests_failed++; $display("FAIL zero_done: got %b required %b", ds, 16'b1000_0000_0000_0000); end
    tests_run++;
    if (xs !== 16'h0000) begin tests_failed++; $display("FAIL zero_x: got %b required %b", xs, 16'h0000); end
  endtask

  // Restart attempt and config changes in cycle 2, abort in cycle 6.
  task automatic test_abort_restart();
    launch(4'b1010, 4'd2, 3'd1, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      xs[16-c] = x_out;
      vs[16-c] = valid;
      bs[16-c] = busy;
      ds[16-c] = done;
      if (c == 2) begin
        start = 1'b1; pattern = 4'b0101; repeat_cnt = 4'd5; gap_len = 3'd0; idle_lvl = 1'b1;
      end
      if (c == 3) begin
        start = 1'b0;
      end
      if (c == 6) abort = 1'b1;
      if (c == 7) abort = 1'b0;
      step();
    end
    tests_run++;
    if (xs !== 16'b1010_0100_0000_0000) begin tests_failed++; $display("FAIL abort_x: got %b required %b", xs, 16'b1010_0100_0000_0000); end
    tests_run++;
    if (vs !== 16'b1111_0100_0000_0000) begin tests_failed++; $display("FAIL abort_valid: got %b required %b", vs, 16'b1111_0100_0000_0000); end
    tests_run++;
    if (bs !== 16'b1111_1100_0000_0000) begin tests_failed++; $display("FAIL abort_busy: got %b required %b", bs, 16'b1111_1100_0000_0000); end
    tests_run++;
    if (ds !== 16'h0000) begin tests_failed++; $display("FAIL abort_done: got %b required %b", ds, 16'h0000); end
  endtask

  task automatic test_abort_with_start();
    abort = 1'b1;
    launch(4'b1111, 4'd2, 3'd0, 1'b0);
    abort = 1'b0;
    capture(xs, vs, bs, ds);
    tests_run++;
    if ({vs, bs, ds} !== 48'h0) begin tests_failed++; $display("FAIL abort_start_idle: got v=%b b=%b d=%b required all 0", vs, bs, ds); end
  endtask

  task automatic test_async_reset();
    launch(4'b1111, 4'd3, 3'd0, 1'b1);
    step();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({x_out, valid, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_reset: got x/v/b/d=%b required 0000", {x_out, valid, busy, done});
    end
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if ({x_out, valid, busy, done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got x/v/b/d=%b required 0000", {x_out, valid, busy, done});
    end
    launch(4'b1001, 4'd1, 3'd0, 1'b0);
    capture(xs, vs, bs, ds);
    tests_run++;
    if (xs !== 16'b1001_0000_0000_0000) begin tests_failed++; $display("FAIL rst_restart_x: got %b required %b", xs, 16'b1001_0000_0000_0000); end
    tests_run++;
    if (vs !== 16'b1111_0000_0000_0000) begin tests_failed++; $display("FAIL rst_restart_valid: got %b required %b", vs, 16'b1111_0000_0000_0000); end
    tests_run++;
    if (ds !== 16'b0000_1000_0000_0000) begin tests_failed++; $display("FAIL rst_restart_done: got %b required %b", ds, 16'b0000_1000_0000_0000); end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pattern    = 4'b0000;
    repeat_cnt = 4'd0;
    gap_len    = 3'd0;
    idle_lvl   = 1'b0;
    abort      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    step();
    test_single();
    test_gap();
    test_back_to_back();
    test_zero_repeat();
    test_abort_restart();
    test_abort_with_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
